// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared display types: converter FSM encoding and digit constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] BCD_ADJ    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a binary source and the BCD converter.
// Latency: n/a (wires only).
// Backpressure: start is ignored while busy; no queueing.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, binary, input busy, done, bcd);
    modport slave  (input start, binary, output busy, done, bcd);
endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3
    import display_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? (d + BCD_ADJ) : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3); BIN_TO_BCD_BLANK_EN blanks leading zeros.
// Latency: done/bcd valid WIDTH cycles after the accept edge; one result per WIDTH+1 cycles.
// Backpressure: start only accepted in IDLE; requests while busy are dropped.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clock,
    input  logic             resetn,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [4*DIGITS-1:0] reset_bcd();
        logic [4*DIGITS-1:0] v;
        v = '0;
`ifdef BIN_TO_BCD_BLANK_EN
        for (int i = 1; i < DIGITS; i++) v[4*i +: 4] = BLANK_CODE;
`endif
        return v;
    endfunction

    localparam logic [4*DIGITS-1:0] RESET_BCD = reset_bcd();

    state_t                state;
    logic [WIDTH-1:0]      operand;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   stepped;
    logic [4*DIGITS-1:0]   result;
    logic [CW-1:0]         count;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .d (scratch[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    // Operand MSB enters the scratch LSB; the corrected scratch top bit falls off.
    assign stepped = {adj[4*DIGITS-2:0], operand[WIDTH-1]};

    always_comb begin
        result = stepped;
`ifdef BIN_TO_BCD_BLANK_EN
        begin : blank
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (stepped[4*i +: 4] != 4'd0) lead = 1'b0;
                if (lead) result[4*i +: 4] = BLANK_CODE;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            operand  <= '0;
            scratch  <= '0;
            count    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.bcd  <= RESET_BCD;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        operand  <= bus.binary;
                        scratch  <= '0;
                        count    <= '0;
                        bus.busy <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch <= stepped;
                    operand <= operand << 1;
                    count   <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        bus.bcd  <= result;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3); honours BIN_TO_BCD_BLANK_EN.
// Stimulus pushes expected results; a negedge monitor pops them on every done pulse.
module tb_bin_to_bcd_seq;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int LAT    = 8;

`ifdef BIN_TO_BCD_BLANK_EN
    localparam logic [11:0] RST_VAL = 12'hFF0;
    localparam logic [11:0] E_ZERO  = 12'hFF0;
    localparam logic [11:0] E_SEVEN = 12'hFF7;
    localparam logic [11:0] E_42    = 12'hF42;
`else
    localparam logic [11:0] RST_VAL = 12'h000;
    localparam logic [11:0] E_ZERO  = 12'h000;
    localparam logic [11:0] E_SEVEN = 12'h007;
    localparam logic [11:0] E_42    = 12'h042;
`endif

    logic clock;
    logic resetn;
    int   checks;
    int   errors;
    int   cyc;
    int   pushed;
    int   dones;

    logic [11:0] exp_q[$];
    int          acc_q[$];

    bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [11:0] ref_bcd(int v);
        logic [3:0] d0, d1, d2;
        logic [11:0] r;
        d0 = 4'(v % 10);
        d1 = 4'((v / 10) % 10);
        d2 = 4'(v / 100);
        r  = {d2, d1, d0};
`ifdef BIN_TO_BCD_BLANK_EN
        if (d2 == 4'd0) r[11:8] = 4'hF;
        if (d2 == 4'd0 && d1 == 4'd0) r[7:4] = 4'hF;
`endif
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (resetn && bus.done) begin
            dones++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got bcd %0h, expected no done", bus.bcd);
            end else begin
                logic [11:0] e;
                int a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                if (bus.bcd !== e) begin
                    errors++;
                    $display("FAIL bcd_result: got %0h, expected %0h", bus.bcd, e);
                end
                checks++;
                if (cyc - a != LAT) begin
                    errors++;
                    $display("FAIL latency: got %0d, expected %0d", cyc - a, LAT);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy %b, expected 0", bus.busy);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic convert(logic [7:0] val, logic [11:0] e);
        wait_idle();
        bus.start  = 1'b1;
        bus.binary = val;
        @(posedge clock);
        #1;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        pushed++;
        bus.start  = 1'b0;
        bus.binary = ~val;
        @(negedge clock);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; pushed = 0; dones = 0;
        resetn = 1'b0;
        bus.start = 1'b0;
        bus.binary = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_bcd", 32'(bus.bcd), 32'(RST_VAL));
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // 255: busy must stay high exactly LAT cycles.
        convert(8'd255, 12'h255);
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clock);
        end
        check("busy_cycles", 32'(n), 32'(LAT));

        convert(8'd0, E_ZERO);

        // Back-to-back: second start lands on the edge after completion.
        convert(8'd7, E_SEVEN);
        convert(8'd100, 12'h100);

        // Starts during busy, including on the completion edge, are dropped.
        convert(8'd42, E_42);
        repeat (2) @(negedge clock);
        bus.start = 1'b1; bus.binary = 8'd9;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        bus.start = 1'b1; bus.binary = 8'd9;
        @(negedge clock);
        bus.start = 1'b0;
        check("idle_after_ignored", 32'(bus.busy), 32'd0);
        @(negedge clock);
        check("still_idle_after_ignored", 32'(bus.busy), 32'd0);
        check("bcd_hold_after_ignored", 32'(bus.bcd), 32'(E_42));

        // Reset at step 4 of 200: no done, bcd returns to reset value.
        wait_idle();
        bus.start = 1'b1; bus.binary = 8'd200;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd", 32'(bus.bcd), 32'(RST_VAL));
        @(negedge clock);
        resetn = 1'b1;
        repeat (12) @(negedge clock);
        check("abort_no_done_bcd", 32'(bus.bcd), 32'(RST_VAL));
        convert(8'd200, 12'h200);

        for (int v = 0; v < 256; v++) convert(8'(v), ref_bcd(v));

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(dones), 32'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
